ste_snd_fifo: RTL and testbench
===============================

Name: ste_snd_fifo

Overview:
- Downstream consumer of the MCU sound DMA handshake. Implements the shifter-side sound FIFO of the STE.
- Raises sreq when it has room and accepts 16-bit words on sload_n strobes.
- Plays 8-bit signed samples at a programmable rate, in mono or stereo, to the audio mixer.

Parameters:
- DEPTH, 4, FIFO depth in 16-bit words (power of two, ≥2).
- BASEDIV, 640, clk32 cycles per 50 kHz base tick (32 MHz / 640 = 50 kHz).

Ports:
- clk32  in  1  system clock, 32 MHz.
- res  in  1  asynchronous active-high reset.
- sndon  in  1  sound DMA enable from MCU control.
- sload_n  in  1  active-low load strobe from MCU, one per requested word.
- din  in  16  data bus word, valid while sload_n low.
- rate  in  2  sample rate select: 0=6.25 kHz, 1=12.5 kHz, 2=25 kHz, 3=50 kHz.
- mono  in  1  1=mono (two samples/word), 0=stereo (L=din[15:8], R=din[7:0]).
- sreq  out  1  sound data request to MCU.
- left  out  8  current left sample, signed.
- right  out  8  current right sample, signed.
- strobe  out  1  one-cycle pulse when left/right update.
- underrun  out  1  one-cycle pulse on a sample tick with FIFO empty.
- overrun  out  1  one-cycle pulse on a load into a full FIFO.

Behaviour:
- Reset (async, res=1):
  - FIFO count, read/write pointers, prescaler and rate counter cleared.
  - Byte phase = high.
  - Outputs sreq=0, left=0, right=0, strobe=0, underrun=0, overrun=0.
- Load detect:
  - sload_n is registered; a high→low transition = one load event.
  - din is captured in the same cycle the low level is first sampled.
  - A held-low strobe loads once only.
- Load timing: the written word is visible in count one cycle after the load event.
- sreq:
  - Registered output. sreq = sndon & (count ≤ DEPTH-2).
  - This leaves one slot for a word already in flight after sreq falls.
- Overflow: a load with count==DEPTH discards the word, pulses overrun, and leaves pointers unchanged.
- Rate ticks:
  - Prescaler counts 0..BASEDIV-1 while sndon=1 and emits a base tick at wrap.
  - A 3-bit divider produces a sample tick every 8/4/2/1 base ticks for rate 0/1/2/3.
  - A rate change takes effect at the next base tick. The divider is not reset.
- Stereo sample tick, FIFO non-empty: pop head word; left=word[15:8], right=word[7:0]; strobe=1 next cycle.
- Mono sample tick, FIFO non-empty:
  - Phase high: left=right=head[15:8], no pop, phase→low.
  - Phase low: left=right=head[7:0], pop, phase→high.
  - strobe each tick.
- Empty FIFO on a sample tick: left/right hold, no strobe, underrun pulse, phase unchanged.
- Simultaneous load and pop in one cycle: both occur and count is unchanged.
- Full FIFO with load and pop in the same cycle: the load is accepted, no overrun.
- mono toggled mid-word: phase is kept. Switching to stereo with phase=low forces phase=high at the next tick, and that tick pops the head word as stereo.
- sndon falling (registered, 1→0), next cycle:
  - FIFO flushed (count=0, pointers=0).
  - Phase=high, prescaler and divider cleared.
  - left=right=0; sreq=0.
  - Loads while sndon=0 are ignored (no overrun).
- sndon rising: sreq rises the next cycle (FIFO empty). The first sample tick occurs BASEDIV×div cycles later.
- Latency: sample tick → left/right/strobe valid 1 cycle later.

Test Plan:
- Reset release with sndon=0, random sload_n pulses → sreq=0, left=right=0, no overrun, count stays 0.
- sndon=1, rate=3, stereo; load 0x7F80 and 0x0102 → sreq drops after 3 words are held (DEPTH=4). First strobe 640 cycles after sndon with left=0x7F, right=0x80; next strobe 640 cycles later with 0x01/0x02.
- Mono, rate=0; one word 0x1234 → strobes 5120 cycles apart give left=right=0x12, then 0x34; third tick → underrun pulse, outputs hold 0x34.
- Fill to 4 words; 5th sload_n with no tick → overrun pulse, head/tail contents unchanged. Then load coincident with a pop at count=4 → accepted, count stays 4.
- Hold sload_n low for 10 cycles → exactly one word written.
- Deassert sndon with 3 words queued and phase=low → next cycle count=0, left=right=0, sreq=0. Re-enable → sreq=1 one cycle later; first mono tick outputs the high byte of the next loaded word.

Source files
------------

// File: rtl/ste_snd_fifo.sv
// STE shifter-side sound FIFO: takes 16-bit DMA words on sload_n strobes and
// plays 8-bit signed samples, mono or stereo, at a programmable rate.
module ste_snd_fifo #(
    parameter int DEPTH   = 4,
    parameter int BASEDIV = 640
) (
    input  logic              clk32,
    input  logic              res,
    input  logic              sndon,
    input  logic              sload_n,
    input  logic [15:0]       din,
    input  logic [1:0]        rate,
    input  logic              mono,
    output logic              sreq,
    output logic signed [7:0] left,
    output logic signed [7:0] right,
    output logic              strobe,
    output logic              underrun,
    output logic              overrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(BASEDIV);

    logic              sload_q, sload_d;
    logic              ld_q, ld_d;
    logic [15:0]       din_q;
    logic [15:0]       mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [2:0]        div_q, div_d;
    logic              phase_q, phase_d;
    logic              sreq_q, sreq_d;
    logic signed [7:0] left_q, left_d, right_q, right_d;
    logic              strobe_q, strobe_d, underrun_q, underrun_d, overrun_q, overrun_d;

    logic        load_ev, base_tick, samp_tick, empty, full, pop, push, wr_en;
    logic [2:0]  div_mask;
    logic [15:0] head;

    always_comb begin
        load_ev   = sload_q & ~sload_n & sndon;
        base_tick = sndon & (presc_q == PW'(BASEDIV - 1));
        unique case (rate)
            2'd0:    div_mask = 3'b111;
            2'd1:    div_mask = 3'b011;
            2'd2:    div_mask = 3'b001;
            default: div_mask = 3'b000;
        endcase
        samp_tick = base_tick & ((div_q & div_mask) == div_mask);
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        head      = mem_q[rptr_q];
        // Stereo always consumes the word; mono only after its low byte.
        pop       = samp_tick & ~empty & (~mono | ~phase_q);
        push      = ld_q & (~full | pop);
        wr_en     = push & sndon;
    end

    always_comb begin
        sload_d    = sload_n;
        ld_d       = load_ev;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        presc_d    = presc_q;
        div_d      = div_q;
        phase_d    = phase_q;
        left_d     = left_q;
        right_d    = right_q;
        strobe_d   = samp_tick & ~empty;
        underrun_d = samp_tick & empty;
        overrun_d  = ld_q & full & ~pop;
        sreq_d     = sndon & (count_q <= CW'(DEPTH - 2));

        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (sndon) begin
            presc_d = base_tick ? '0 : presc_q + 1'b1;
            if (base_tick) begin
                div_d = div_q + 3'd1;
            end
        end

        if (samp_tick && !empty) begin
            if (!mono) begin
                left_d  = $signed(head[15:8]);
                right_d = $signed(head[7:0]);
                phase_d = 1'b1;
            end else if (phase_q) begin
                left_d  = $signed(head[15:8]);
                right_d = $signed(head[15:8]);
                phase_d = 1'b0;
            end else begin
                left_d  = $signed(head[7:0]);
                right_d = $signed(head[7:0]);
                phase_d = 1'b1;
            end
        end

        // Sound off: flush everything and silence the outputs.
        if (!sndon) begin
            ld_d       = 1'b0;
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            presc_d    = '0;
            div_d      = '0;
            phase_d    = 1'b1;
            left_d     = '0;
            right_d    = '0;
            strobe_d   = 1'b0;
            underrun_d = 1'b0;
            overrun_d  = 1'b0;
            sreq_d     = 1'b0;
        end
    end

    always_ff @(posedge clk32 or posedge res) begin
        if (res) begin
            sload_q    <= 1'b1;
            ld_q       <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            presc_q    <= '0;
            div_q      <= '0;
            phase_q    <= 1'b1;
            sreq_q     <= 1'b0;
            left_q     <= '0;
            right_q    <= '0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sload_q    <= sload_d;
            ld_q       <= ld_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            sreq_q     <= sreq_d;
            left_q     <= left_d;
            right_q    <= right_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    // Data storage carries no reset; the count alone qualifies its contents.
    always_ff @(posedge clk32) begin
        if (load_ev) begin
            din_q <= din;
        end
        if (wr_en) begin
            mem_q[wptr_q] <= din_q;
        end
    end

    assign sreq     = sreq_q;
    assign left     = left_q;
    assign right    = right_q;
    assign strobe   = strobe_q;
    assign underrun = underrun_q;
    assign overrun  = overrun_q;
endmodule

// File: tb/tb_ste_snd_fifo.sv
// Directed bench for ste_snd_fifo: a queue of expected {left,right} pairs is
// filled as words are loaded and drained whenever the DUT strobes.
`timescale 1ns/1ps
module tb_ste_snd_fifo;
    localparam int DEPTH   = 4;
    localparam int BASEDIV = 640;

    logic              clk32 = 1'b0;
    logic              res, sndon, sload_n, mono;
    logic [15:0]       din;
    logic [1:0]        rate;
    logic              sreq, strobe, underrun, overrun;
    logic signed [7:0] left, right;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc_cnt = 0;
    int          n_under = 0;
    int          n_over  = 0;
    logic [15:0] sb[$];

    ste_snd_fifo #(.DEPTH(DEPTH), .BASEDIV(BASEDIV)) dut (
        .clk32(clk32), .res(res), .sndon(sndon), .sload_n(sload_n), .din(din),
        .rate(rate), .mono(mono), .sreq(sreq), .left(left), .right(right),
        .strobe(strobe), .underrun(underrun), .overrun(overrun)
    );

    always #5 clk32 = ~clk32;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon();
        logic [15:0] e;
        if (strobe === 1'b1) begin
            if (sb.size() == 0) begin
                chk("strobe_expected", 32'(strobe), 0);
            end else begin
                e = sb.pop_front();
                chk("strobe_lr", {16'h0, left, right}, {16'h0, e});
            end
        end
        if (underrun === 1'b1) n_under++;
        if (overrun === 1'b1) n_over++;
    endtask

    task automatic cyc();
        @(posedge clk32);
        #1;
        cyc_cnt++;
        mon();
    endtask

    task automatic load_word(input logic [15:0] w);
        din     = w;
        sload_n = 1'b0;
        cyc();
        sload_n = 1'b1;
        din     = 16'($urandom);
        cyc();
    endtask

    task automatic wait_strobe(input string tag, input int maxc);
        int el;
        el = 0;
        do begin
            cyc();
            el++;
        end while (strobe !== 1'b1 && el < maxc);
        chk({tag, "_seen"}, 32'(strobe), 1);
    endtask

    task automatic wait_under(input string tag, input int maxc);
        int el;
        el = 0;
        do begin
            cyc();
            el++;
        end while (underrun !== 1'b1 && el < maxc);
        chk({tag, "_seen"}, 32'(underrun), 1);
    endtask

    task automatic restart(input logic m, input logic [1:0] r);
        sndon = 1'b0;
        cyc();
        sb.delete();
        mono  = m;
        rate  = r;
        sndon = 1'b1;
    endtask

    initial begin
        int t0, t1, o0;
        res = 1'b1; sndon = 1'b0; sload_n = 1'b1; din = '0; rate = '0; mono = 1'b0;
        cyc(); cyc();
        chk("rst_sreq", 32'(sreq), 0);
        chk("rst_lr", {16'h0, left, right}, 0);
        chk("rst_pulses", {29'h0, strobe, underrun, overrun}, 0);
        res = 1'b0;

        // sound off: strobes must be ignored
        for (int i = 0; i < 24; i++) begin
            sload_n = 1'($urandom_range(0, 1));
            din     = 16'($urandom);
            cyc();
        end
        sload_n = 1'b1;
        cyc(); cyc();
        chk("off_sreq", 32'(sreq), 0);
        chk("off_lr", {16'h0, left, right}, 0);
        chk("off_overrun", 32'(n_over), 0);

        // stereo, 50 kHz
        rate = 2'd3; mono = 1'b0; sndon = 1'b1; t0 = cyc_cnt;
        cyc();
        chk("sreq_rise", 32'(sreq), 1);
        load_word(16'h7F80); sb.push_back(16'h7F80);
        load_word(16'h0102); sb.push_back(16'h0102);
        cyc();
        chk("sreq_two_words", 32'(sreq), 1);
        load_word(16'hFF00); sb.push_back(16'hFF00);
        cyc();
        chk("sreq_three_words", 32'(sreq), 0);
        wait_strobe("st1", 700);
        chk("st1_latency", 32'(cyc_cnt - t0), BASEDIV);
        t1 = cyc_cnt;
        cyc();
        chk("sreq_after_pop", 32'(sreq), 1);
        wait_strobe("st2", 700);
        chk("st2_interval", 32'(cyc_cnt - t1), BASEDIV);
        wait_strobe("st3", 700);
        t1 = cyc_cnt;
        o0 = n_under;
        wait_under("st_under", 700);
        chk("st_under_interval", 32'(cyc_cnt - t1), BASEDIV);
        chk("st_under_hold", {16'h0, left, right}, 32'h0000_FF00);
        chk("st_under_count", 32'(n_under - o0), 1);

        // flush, then mono at 6.25 kHz
        sndon = 1'b0;
        cyc();
        chk("flush_lr", {16'h0, left, right}, 0);
        chk("flush_sreq", 32'(sreq), 0);
        mono = 1'b1; rate = 2'd0; sndon = 1'b1; t0 = cyc_cnt;
        load_word(16'h1234);
        sb.push_back(16'h1212); sb.push_back(16'h3434);
        wait_strobe("mo1", 5200);
        chk("mo1_latency", 32'(cyc_cnt - t0), 8 * BASEDIV);
        t1 = cyc_cnt;
        wait_strobe("mo2", 5200);
        chk("mo2_interval", 32'(cyc_cnt - t1), 8 * BASEDIV);
        t1 = cyc_cnt;
        wait_under("mo_under", 5200);
        chk("mo_under_interval", 32'(cyc_cnt - t1), 8 * BASEDIV);
        chk("mo_under_hold", {16'h0, left, right}, 32'h0000_3434);

        // overrun, then load coincident with a pop while full
        restart(1'b0, 2'd0); t0 = cyc_cnt;
        load_word(16'h0A0B); sb.push_back(16'h0A0B);
        load_word(16'h1C1D); sb.push_back(16'h1C1D);
        load_word(16'h2E2F); sb.push_back(16'h2E2F);
        load_word(16'h3031); sb.push_back(16'h3031);
        o0 = n_over;
        load_word(16'h4444);
        chk("overrun_pulse", 32'(n_over - o0), 1);
        chk("full_sreq", 32'(sreq), 0);
        o0 = n_over;
        while (cyc_cnt < t0 + 8 * BASEDIV - 2) cyc();
        din = 16'h5566; sload_n = 1'b0;
        sb.push_back(16'h5566);
        cyc();
        sload_n = 1'b1;
        cyc();
        chk("coincident_pop", 32'(strobe), 1);
        rate = 2'd3;
        t1 = cyc_cnt;
        wait_strobe("rate_change", 700);
        chk("rate_change_interval", 32'(cyc_cnt - t1), BASEDIV);
        wait_strobe("fl3", 700);
        wait_strobe("fl4", 700);
        wait_strobe("fl5", 700);
        wait_under("fl_under", 700);
        chk("coincident_no_overrun", 32'(n_over - o0), 0);

        // held-low strobe loads once
        restart(1'b0, 2'd3);
        cyc();
        din = 16'h1111; sload_n = 1'b0;
        sb.push_back(16'h1111);
        cyc();
        for (int i = 0; i < 9; i++) begin
            din = 16'($urandom);
            cyc();
        end
        sload_n = 1'b1;
        wait_strobe("held", 700);
        wait_under("held_under", 700);

        // sndon drop mid-word with words queued
        restart(1'b1, 2'd3);
        load_word(16'hA1B2); sb.push_back(16'hA1A1);
        load_word(16'hC3D4);
        load_word(16'hE5F6);
        wait_strobe("drop_pre", 700);
        sndon = 1'b0;
        cyc();
        chk("drop_lr", {16'h0, left, right}, 0);
        chk("drop_sreq", 32'(sreq), 0);
        cyc();
        sndon = 1'b1; t0 = cyc_cnt;
        cyc();
        chk("reen_sreq", 32'(sreq), 1);
        load_word(16'h5A6B); sb.push_back(16'h5A5A);
        wait_strobe("reen_hi", 700);
        chk("reen_latency", 32'(cyc_cnt - t0), BASEDIV);
        mono = 1'b0;
        sb.push_back(16'h5A6B);
        wait_strobe("mono_to_stereo", 700);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
